// File: rtl/paillier_mod_mult.sv
// paillier_mod_mult: bit-serial interleaved (Blakley) modular multiplier.
// Computes R = a*b mod p, taking one multiplier bit per clock, MSB first.
// It sits after the modular inverse stage in the Paillier decrypt path and
// uses the same valid_in / valid_out / busy handshake.
module paillier_mod_mult #(
  parameter int Data_Width = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Data_Width-1:0] a,
  input  logic [Data_Width-1:0] b,
  input  logic [Data_Width-1:0] p,
  input  logic                  valid_in,
  output logic [Data_Width-1:0] R,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int W  = Data_Width;
  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  p_r;
  logic [W+1:0]  acc;
  logic [CW-1:0] cnt;

  logic [W+1:0]  t;
  logic [W+2:0]  t1;
  logic [W+2:0]  t2;
  logic [W+1:0]  acc_next;

  // One Blakley step: double, conditionally add a, then subtract 0, p or 2p.
  // With p = 0 both trial subtractions are never negative, so the select
  // is forced to zero to give a defined R = 0 result.
  always_comb begin
    t  = {acc[W:0], 1'b0} + (b_r[W-1] ? {2'b00, a_r} : '0);
    t1 = {1'b0, t} - {3'b000, p_r};
    t2 = {1'b0, t} - {2'b00, p_r, 1'b0};
    if (p_r == '0) begin
      acc_next = '0;
    end else if (!t2[W+2]) begin
      acc_next = t2[W+1:0];
    end else if (!t1[W+2]) begin
      acc_next = t1[W+1:0];
    end else begin
      acc_next = t;
    end
  end

  // Control FSM and datapath registers. R is loaded on the edge entering
  // DONE (from the final iteration result) so it is valid in the same cycle
  // as the valid_out pulse, and then held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      p_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      R         <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            a_r   <= a;
            b_r   <= b;
            p_r   <= p;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          b_r <= {b_r[W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            R         <= acc_next[W-1:0];
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paillier_mod_mult.sv
// tb_paillier_mod_mult: directed, table-driven bench for the 8-bit
// configuration of paillier_mod_mult, with hand-written sequences for
// handshake timing, back-to-back issue, ignored requests and mid-run reset.
module tb_paillier_mod_mult;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         valid_in;
  logic [W-1:0] R;
  logic         valid_out;
  logic         busy;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] exp_r;
  } vec_t;

  vec_t vecs[10];

  paillier_mod_mult #(.Data_Width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .p         (p),
    .valid_in  (valid_in),
    .R         (R),
    .valid_out (valid_out),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Run one operation. lat is the cycle number (valid_in cycle = 0) in which
  // valid_out is seen, or -1 on timeout. With disturb set, a second request
  // with different operands is pulsed mid-run and the inputs are left changed.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] pv, input bit disturb,
                               output logic [W-1:0] r, output int lat);
    a = av;
    b = bv;
    p = pv;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    lat = -1;
    r = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (disturb && k == 3) begin
        a = 8'd3;
        b = 8'd4;
        p = 8'd13;
        valid_in = 1'b1;
      end
      step();
      valid_in = 1'b0;
      if (valid_out === 1'b1) begin
        lat = k + 1;
        r = R;
        break;
      end
    end
    step();
    checkOutput("pulse_width", 32'(valid_out), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] r;
    int           lat;
    int           spurious;

    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    p        = '0;
    valid_in = 1'b0;

    vecs[0] = '{8'd5,   8'd7,   8'd11,  8'd2};
    vecs[1] = '{8'd250, 8'd250, 8'd251, 8'd1};
    vecs[2] = '{8'd0,   8'd123, 8'd251, 8'd0};
    vecs[3] = '{8'd1,   8'd200, 8'd251, 8'd200};
    vecs[4] = '{8'd12,  8'd13,  8'd251, 8'd156};
    vecs[5] = '{8'd200, 8'd200, 8'd251, 8'd91};
    vecs[6] = '{8'd254, 8'd254, 8'd255, 8'd1};
    vecs[7] = '{8'd127, 8'd2,   8'd255, 8'd254};
    vecs[8] = '{8'd0,   8'd0,   8'd1,   8'd0};
    vecs[9] = '{8'd6,   8'd6,   8'd7,   8'd1};

    #2;
    checkOutput("reset_R", 32'(R), 32'd0);
    checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] timing trace for 5*7 mod 11");
    a = 8'd5;
    b = 8'd7;
    p = 8'd11;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    checkOutput("busy_cycle1", 32'(busy), 32'd1);
    checkOutput("valid_out_cycle1", 32'(valid_out), 32'd0);
    for (int k = 1; k <= W; k++) begin
      step();
      checkOutput("busy_trace", 32'(busy), 32'd1);
      checkOutput("valid_out_trace", 32'(valid_out), (k == W) ? 32'd1 : 32'd0);
      if (k == W) checkOutput("trace_R", 32'(R), 32'd2);
    end
    step();
    checkOutput("trace_idle_busy", 32'(busy), 32'd0);
    checkOutput("trace_idle_valid_out", 32'(valid_out), 32'd0);
    checkOutput("trace_R_held", 32'(R), 32'd2);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, r, lat);
      checkOutput($sformatf("table_R[%0d]", i), 32'(r), 32'(vecs[i].exp_r));
      checkOutput($sformatf("table_latency[%0d]", i), 32'(lat), 32'(W + 1));
    end

    $display("[TB] zero modulus");
    applyStimulus(8'd5, 8'd7, 8'd0, 1'b0, r, lat);
    checkOutput("p0_R", 32'(r), 32'd0);
    checkOutput("p0_latency", 32'(lat), 32'(W + 1));

    $display("[TB] back-to-back");
    applyStimulus(8'd5, 8'd7, 8'd11, 1'b0, r, lat);
    checkOutput("b2b_first_R", 32'(r), 32'd2);
    applyStimulus(8'd3, 8'd4, 8'd13, 1'b0, r, lat);
    checkOutput("b2b_second_R", 32'(r), 32'd12);
    checkOutput("b2b_second_latency", 32'(lat), 32'(W + 1));

    $display("[TB] reset during run");
    a = 8'd5;
    b = 8'd7;
    p = 8'd11;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("midrst_R", 32'(R), 32'd0);
    step();
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (valid_out !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checkOutput("midrst_no_spurious", 32'(spurious), 32'd0);
    applyStimulus(8'd9, 8'd9, 8'd17, 1'b0, r, lat);
    checkOutput("after_rst_R", 32'(r), 32'd13);
    checkOutput("after_rst_latency", 32'(lat), 32'(W + 1));

    $display("[TB] ignored request while busy");
    applyStimulus(8'd5, 8'd7, 8'd11, 1'b1, r, lat);
    checkOutput("ignore_R", 32'(r), 32'd2);
    checkOutput("ignore_latency", 32'(lat), 32'(W + 1));
    spurious = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (valid_out !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checkOutput("ignore_no_restart", 32'(spurious), 32'd0);
    checkOutput("ignore_R_held", 32'(R), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
